// File: rtl/ram_arbiter_if.sv
// Bundle of requester handshakes and RAM command pins around ram_arbiter.
// slave: the arbiter's view. master: the requesters plus the RAM.
interface ram_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    // Port A requester
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt;
    logic          a_rvalid;
    logic          a_oor;
    logic [DW-1:0] a_rdata;

    // Port B requester
    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt;
    logic          b_rvalid;
    logic          b_oor;
    logic [DW-1:0] b_rdata;

    logic          busy;

    // RAM pins
    logic          ram_cs;
    logic          ram_read;
    logic          ram_write;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_datawrite;
    logic [DW-1:0] ram_dataread;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  ram_dataread,
        output a_gnt, a_rvalid, a_oor, a_rdata,
        output b_gnt, b_rvalid, b_oor, b_rdata,
        output busy,
        output ram_cs, ram_read, ram_write, ram_address, ram_datawrite
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output ram_dataread,
        input  a_gnt, a_rvalid, a_oor, a_rdata,
        input  b_gnt, b_rvalid, b_oor, b_rdata,
        input  busy,
        input  ram_cs, ram_read, ram_write, ram_address, ram_datawrite
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a single synchronous RAM.
// Every output is a register; next values are computed from the next state.
module ram_arbiter #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 8
) (
    input logic            clk,
    input logic            rst_n,
    ram_arbiter_if.slave   bus_io
);

    typedef enum logic [1:0] {StIdle, StCmd, StResp} state_e;

    state_e        state_q, state_d;
    logic          last_b_q, last_b_d;   // 1: B was granted last
    logic          own_b_q, own_b_d;     // owner of the operation in flight
    logic          we_q, we_d;
    logic          inr_q, inr_d;         // latched address-in-range flag

    logic          a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic          a_oor_q, a_oor_d, b_oor_q, b_oor_d;
    logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic          busy_q, busy_d;
    logic          cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          win_b;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_inr;

    // Winner selection: a lone requester wins; on contention the port not granted last wins.
    always_comb begin
        win_b     = bus_io.b_req && (!bus_io.a_req || !last_b_q);
        sel_we    = win_b ? bus_io.b_we    : bus_io.a_we;
        sel_addr  = win_b ? bus_io.b_addr  : bus_io.a_addr;
        sel_wdata = win_b ? bus_io.b_wdata : bus_io.a_wdata;
        sel_inr   = 32'(sel_addr) < DEPTH;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        own_b_d    = own_b_q;
        we_d       = we_q;
        inr_d      = inr_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_oor_d    = 1'b0;
        b_oor_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        cs_d       = 1'b0;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        addr_d     = '0;
        wdata_d    = '0;

        unique case (state_q)
            StIdle: begin
                if (bus_io.a_req || bus_io.b_req) begin
                    state_d  = StCmd;
                    last_b_d = win_b;
                    own_b_d  = win_b;
                    we_d     = sel_we;
                    inr_d    = sel_inr;
                    a_gnt_d  = !win_b;
                    b_gnt_d  = win_b;
                    a_oor_d  = !win_b && !sel_inr;
                    b_oor_d  = win_b && !sel_inr;
                    // Out-of-range commands never reach the RAM.
                    cs_d     = sel_inr;
                    wr_d     = sel_inr && sel_we;
                    rd_d     = sel_inr && !sel_we;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                end
            end
            StCmd: begin
                state_d = we_q ? StIdle : StResp;
            end
            StResp: begin
                // RAM registered the word at the end of CMD; capture it now.
                state_d = StIdle;
                if (own_b_q) begin
                    b_rvalid_d = 1'b1;
                    b_rdata_d  = inr_q ? bus_io.ram_dataread : '0;
                end else begin
                    a_rvalid_d = 1'b1;
                    a_rdata_d  = inr_q ? bus_io.ram_dataread : '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset clears everything and favours A next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_b_q   <= 1'b1;
            own_b_q    <= 1'b0;
            we_q       <= 1'b0;
            inr_q      <= 1'b0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_oor_q    <= 1'b0;
            b_oor_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            busy_q     <= 1'b0;
            cs_q       <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            own_b_q    <= own_b_d;
            we_q       <= we_d;
            inr_q      <= inr_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_oor_q    <= a_oor_d;
            b_oor_q    <= b_oor_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            busy_q     <= busy_d;
            cs_q       <= cs_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Output drive.
    always_comb begin
        bus_io.a_gnt         = a_gnt_q;
        bus_io.b_gnt         = b_gnt_q;
        bus_io.a_oor         = a_oor_q;
        bus_io.b_oor         = b_oor_q;
        bus_io.a_rvalid      = a_rvalid_q;
        bus_io.b_rvalid      = b_rvalid_q;
        bus_io.a_rdata       = a_rdata_q;
        bus_io.b_rdata       = b_rdata_q;
        bus_io.busy          = busy_q;
        bus_io.ram_cs        = cs_q;
        bus_io.ram_read      = rd_q;
        bus_io.ram_write     = wr_q;
        bus_io.ram_address   = addr_q;
        bus_io.ram_datawrite = wdata_q;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural RAM, plus a transaction-level reference
// (memory array, last-grant flag, per-port read data) checked every cycle.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ram_arbiter_if #(.AW(8), .DW(8)) bus ();

    ram_arbiter #(.DEPTH(32), .AW(8), .DW(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    // Synchronous 32 x 8 RAM; read data registered on the sampling edge.
    logic [7:0] ram [32];
    always @(posedge clk) begin
        if (bus.ram_cs) begin
            if (bus.ram_write) ram[bus.ram_address[4:0]] <= bus.ram_datawrite;
            if (bus.ram_read)  bus.ram_dataread <= ram[bus.ram_address[4:0]];
        end
    end

    // Reference state.
    logic [7:0] ref_mem [32];
    int         m_last;          // 0: A granted last, 1: B
    logic [7:0] m_rd [2];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 0) ? bus.a_gnt : bus.b_gnt;
    endfunction
    function automatic logic oor_of(input int p);
        return (p == 0) ? bus.a_oor : bus.b_oor;
    endfunction
    function automatic logic rv_of(input int p);
        return (p == 0) ? bus.a_rvalid : bus.b_rvalid;
    endfunction

    task automatic drive(input int p, input bit v, input bit we, input logic [7:0] ad,
                         input logic [7:0] wd);
        if (p == 0) begin
            bus.a_req = v; bus.a_we = we; bus.a_addr = ad; bus.a_wdata = wd;
        end else begin
            bus.b_req = v; bus.b_we = we; bus.b_addr = ad; bus.b_wdata = wd;
        end
    endtask

    task automatic chk_rdata();
        chk("a_rdata", bus.a_rdata, m_rd[0]);
        chk("b_rdata", bus.b_rdata, m_rd[1]);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_a_gnt"}, bus.a_gnt, 0);
        chk({tag, "_b_gnt"}, bus.b_gnt, 0);
        chk({tag, "_a_oor"}, bus.a_oor, 0);
        chk({tag, "_b_oor"}, bus.b_oor, 0);
        chk({tag, "_cs"}, bus.ram_cs, 0);
        chk({tag, "_rd"}, bus.ram_read, 0);
        chk({tag, "_wr"}, bus.ram_write, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_quiet(tag);
        chk({tag, "_a_rv"}, bus.a_rvalid, 0);
        chk({tag, "_b_rv"}, bus.b_rvalid, 0);
        chk({tag, "_a_rdata"}, bus.a_rdata, 0);
        chk({tag, "_b_rdata"}, bus.b_rdata, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_addr"}, bus.ram_address, 0);
        chk({tag, "_wdata"}, bus.ram_datawrite, 0);
    endtask

    // Present up to one request per port (caller sits just after a rising edge, DUT idle)
    // and follow every cycle until both are served.
    task automatic do_ops(input bit av, input bit awe, input logic [7:0] aad, input logic [7:0] awd,
                          input bit bv, input bit bwe, input logic [7:0] bad, input logic [7:0] bwd);
        bit         pend [2];
        bit         we [2];
        logic [7:0] ad [2];
        logic [7:0] wd [2];
        int         w;
        bit         inr;
        pend[0] = av;  pend[1] = bv;
        we[0] = awe;   we[1] = bwe;
        ad[0] = aad;   ad[1] = bad;
        wd[0] = awd;   wd[1] = bwd;
        drive(0, av, awe, aad, awd);
        drive(1, bv, bwe, bad, bwd);
        if (!av && !bv) begin
            @(posedge clk); #1;
            chk_quiet("idle");
            chk("idle_busy", bus.busy, 0);
            chk_rdata();
            return;
        end
        while (pend[0] || pend[1]) begin
            if (pend[0] && pend[1]) w = (m_last == 1) ? 0 : 1;
            else                    w = pend[0] ? 0 : 1;
            inr = (ad[w] < 8'd32);
            // Grant / command cycle
            @(posedge clk); #1;
            chk("gnt_win", gnt_of(w), 1);
            chk("gnt_lose", gnt_of(1 - w), 0);
            chk("oor_win", oor_of(w), !inr);
            chk("oor_lose", oor_of(1 - w), 0);
            chk("cmd_cs", bus.ram_cs, inr);
            chk("cmd_wr", bus.ram_write, inr && we[w]);
            chk("cmd_rd", bus.ram_read, inr && !we[w]);
            chk("cmd_addr", bus.ram_address, ad[w]);
            chk("cmd_wdata", bus.ram_datawrite, wd[w]);
            chk("cmd_busy", bus.busy, 1);
            chk("cmd_rv_a", bus.a_rvalid, 0);
            chk("cmd_rv_b", bus.b_rvalid, 0);
            chk_rdata();
            drive(w, 1'b0, we[w], ad[w], wd[w]);
            pend[w] = 0;
            m_last = w;
            if (we[w] && inr) ref_mem[ad[w][4:0]] = wd[w];
            @(posedge clk); #1;
            chk_quiet("post_cmd");
            chk("post_rv_a", bus.a_rvalid, 0);
            chk("post_rv_b", bus.b_rvalid, 0);
            chk_rdata();
            if (!we[w]) begin
                chk("resp_busy", bus.busy, 1);
                @(posedge clk); #1;
                m_rd[w] = inr ? ref_mem[ad[w][4:0]] : 8'h00;
                chk("rv_win", rv_of(w), 1);
                chk("rv_lose", rv_of(1 - w), 0);
                chk_quiet("rv");
                chk("rv_busy", bus.busy, 0);
                chk_rdata();
            end else begin
                chk("wr_busy", bus.busy, 0);
            end
        end
    endtask

    // Assert reset a little after an edge, check outputs at once and across an edge.
    task automatic reset_pulse(input string tag);
        #2;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        chk_all_zero({tag, "_now"});
        @(posedge clk); #1;
        chk_all_zero({tag, "_held"});
        rst_n = 1'b1;
        m_last = 1;
        m_rd[0] = 8'h00;
        m_rd[1] = 8'h00;
    endtask

    initial begin
        logic [7:0] v;
        m_last = 1;
        m_rd[0] = 8'h00;
        m_rd[1] = 8'h00;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);

        // Reset state
        #1;
        chk_all_zero("reset");
        @(posedge clk); #1;
        chk_all_zero("reset_edge");
        rst_n = 1'b1;

        // Fill the RAM so every later read has a known value.
        for (int i = 0; i < 32; i++) begin
            v = 8'($urandom);
            if (i % 2 == 0) do_ops(1, 1, 8'(i), v, 0, 0, 8'h00, 8'h00);
            else            do_ops(0, 0, 8'h00, 8'h00, 1, 1, 8'(i), v);
        end

        // A writes then reads address 5.
        do_ops(1, 1, 8'd5, 8'hA5, 0, 0, 8'h00, 8'h00);
        do_ops(1, 0, 8'd5, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("a_rdata_a5", bus.a_rdata, 8'hA5);

        // Contending writes, then contending reads.
        do_ops(1, 1, 8'd1, 8'h11, 1, 1, 8'd2, 8'h22);
        do_ops(1, 0, 8'd1, 8'h00, 1, 0, 8'd2, 8'h00);
        chk("rd_11", bus.a_rdata, 8'h11);
        chk("rd_22", bus.b_rdata, 8'h22);

        // Out-of-range read on B.
        do_ops(0, 0, 8'h00, 8'h00, 1, 0, 8'd40, 8'h00);
        chk("oor_rdata", bus.b_rdata, 8'h00);

        // Reset during the CMD cycle of a write: the write must be lost.
        do_ops(1, 1, 8'd3, 8'h33, 0, 0, 8'h00, 8'h00);
        drive(0, 1'b1, 1'b1, 8'd3, 8'hFF);
        @(posedge clk); #1;
        chk("cut_wr_gnt", bus.a_gnt, 1);
        chk("cut_wr_cs", bus.ram_cs, 1);
        reset_pulse("rst_cmd");
        do_ops(1, 0, 8'd3, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("rd_after_cut", bus.a_rdata, 8'h33);

        // Reset during RESP of a read: no rvalid, then fresh arbitration.
        drive(0, 1'b1, 1'b0, 8'd2, 8'h00);
        @(posedge clk); #1;
        chk("cut_rd_gnt", bus.a_gnt, 1);
        drive(0, 1'b0, 1'b0, 8'd2, 8'h00);
        @(posedge clk); #1;
        chk("cut_rd_busy", bus.busy, 1);
        reset_pulse("rst_resp");
        do_ops(1, 0, 8'd1, 8'h00, 1, 0, 8'd2, 8'h00);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            do_ops(1'($urandom), 1'($urandom), 8'($urandom_range(0, 47)), 8'($urandom),
                   1'($urandom), 1'($urandom), 8'($urandom_range(0, 47)), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
